// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared instruction/result types and execute-stage FSM states
package instr_register_pkg;

    typedef logic [4:0]         address_t;
    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;

    // Encodings 8..15 are undefined and execute as ZERO.
    typedef enum logic [3:0] {
        OP_ZERO  = 4'd0,
        OP_PASSA = 4'd1,
        OP_PASSB = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MULT  = 4'd5,
        OP_DIV   = 4'd6,
        OP_MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t operand_a;
        operand_t operand_b;
    } instruction_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_DIV   = 3'd3,
        ST_WB    = 3'd4,
        ST_FIN   = 3'd5
    } exec_state_t;

    function automatic logic is_divide(opcode_t op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per cycle
module seq_divider #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);
    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [31:0]      quo_q, rem_q, divisor_q;
    logic [CNT_W-1:0] cnt_q;
    logic             running_q;

    logic [31:0] rem_in, quo_in, div_in, rem_nx, quo_nx;
    logic [32:0] shifted, trial;

    // One restoring step; on the launch cycle it works straight from the inputs so
    // the last bit is ready in exactly DIV_CYCLES cycles.
    always_comb begin
        rem_in  = start ? 32'd0    : rem_q;
        quo_in  = start ? dividend : quo_q;
        div_in  = start ? divisor  : divisor_q;
        shifted = {rem_in, quo_in[31]};
        trial   = shifted - {1'b0, div_in};
        if (!trial[32]) begin
            rem_nx = trial[31:0];
            quo_nx = {quo_in[30:0], 1'b1};
        end else begin
            rem_nx = shifted[31:0];
            quo_nx = {quo_in[30:0], 1'b0};
        end
    end

    // Iteration registers and remaining-step counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            quo_q     <= quo_nx;
            rem_q     <= rem_nx;
            divisor_q <= divisor;
            cnt_q     <= CNT_W'(DIV_CYCLES - 1);
            running_q <= 1'b1;
        end else if (running_q) begin
            if (cnt_q != '0) begin
                quo_q <= quo_nx;
                rem_q <= rem_nx;
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                running_q <= 1'b0;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = running_q && (cnt_q == '0);

endmodule

// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - walks instruction-register entries and executes each one
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     first_addr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output result_t      result,
    output address_t     result_addr,
    output logic         result_valid,
    output logic         busy,
    output logic         done
);
    exec_state_t  state_q, state_d;
    address_t     ptr_q, ptr_d;
    logic [5:0]   remaining_q, remaining_d;
    instruction_t ir_q, ir_d;
    result_t      result_q, result_d;
    address_t     result_addr_q, result_addr_d;

    logic         div_start, div_done;
    logic [31:0]  mag_a, mag_b, div_quo, div_rem;
    logic [63:0]  div_mag;
    logic         div_neg;
    result_t      alu_result, div_result;

    assign mag_a = ir_q.operand_a[31] ? 32'(-ir_q.operand_a) : 32'(ir_q.operand_a);
    assign mag_b = ir_q.operand_b[31] ? 32'(-ir_q.operand_b) : 32'(ir_q.operand_b);

    seq_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Single-cycle opcodes; a divide that reaches here has a zero divisor and yields 0.
    always_comb begin
        alu_result = '0;
        case (ir_q.opcode)
            OP_PASSA: alu_result = result_t'(ir_q.operand_a);
            OP_PASSB: alu_result = result_t'(ir_q.operand_b);
            OP_ADD:   alu_result = result_t'(ir_q.operand_a) + result_t'(ir_q.operand_b);
            OP_SUB:   alu_result = result_t'(ir_q.operand_a) - result_t'(ir_q.operand_b);
            OP_MULT:  alu_result = result_t'(ir_q.operand_a) * result_t'(ir_q.operand_b);
            default:  alu_result = '0;
        endcase
    end

    // Sign fix of the unsigned divider output: quotient takes sign(a)^sign(b), remainder sign(a).
    always_comb begin
        if (ir_q.opcode == OP_DIV) begin
            div_mag = {32'd0, div_quo};
            div_neg = ir_q.operand_a[31] ^ ir_q.operand_b[31];
        end else begin
            div_mag = {32'd0, div_rem};
            div_neg = ir_q.operand_a[31];
        end
        div_result = div_neg ? result_t'(-div_mag) : result_t'(div_mag);
    end

    // Run sequencing: fetch, execute (optionally divide), write back, repeat.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        remaining_d   = remaining_q;
        ir_d          = ir_q;
        result_d      = result_q;
        result_addr_d = result_addr_q;
        div_start     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d       = first_addr;
                    remaining_d = count;
                    state_d     = (count == 6'd0) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = instruction_word;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_divide(ir_q.opcode) && (ir_q.operand_b != 0)) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end else begin
                    result_d      = alu_result;
                    result_addr_d = ptr_q;
                    state_d       = ST_WB;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    result_d      = div_result;
                    result_addr_d = ptr_q;
                    state_d       = ST_WB;
                end
            end
            ST_WB: begin
                ptr_d       = ptr_q + 5'd1;
                remaining_d = remaining_q - 6'd1;
                state_d     = (remaining_q == 6'd1) ? ST_FIN : ST_FETCH;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            remaining_q   <= '0;
            ir_q          <= '0;
            result_q      <= '0;
            result_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            remaining_q   <= remaining_d;
            ir_q          <= ir_d;
            result_q      <= result_d;
            result_addr_q <= result_addr_d;
        end
    end

    assign read_pointer = ptr_q;
    assign result       = result_q;
    assign result_addr  = result_addr_q;
    assign result_valid = (state_q == ST_WB);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FIN);

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb/tb_instr_exec_unit.sv - randomized bench for instr_exec_unit against a behavioural model
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    localparam int DIVC = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    address_t     first_addr = '0;
    logic [5:0]   count = '0;
    address_t     read_pointer;
    instruction_t instruction_word;
    result_t      result;
    address_t     result_addr;
    logic         result_valid, busy, done;

    instruction_t mem [32];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_exec_unit #(.DIV_CYCLES(DIVC)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result           (result),
        .result_addr      (result_addr),
        .result_valid     (result_valid),
        .busy             (busy),
        .done             (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic instruction_t mk(input opcode_t op, input int a, input int b);
        instruction_t ins;
        ins.opcode    = op;
        ins.operand_a = operand_t'(a);
        ins.operand_b = operand_t'(b);
        return ins;
    endfunction

    // Reference semantics: plain 64-bit signed arithmetic (SV / truncates, % follows dividend).
    function automatic longint model(input instruction_t ins);
        longint a, b;
        a = longint'(ins.operand_a);
        b = longint'(ins.operand_b);
        case (ins.opcode)
            OP_PASSA: return a;
            OP_PASSB: return b;
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_MULT:  return a * b;
            OP_DIV:   return (b == 0) ? 64'sd0 : a / b;
            OP_MOD:   return (b == 0) ? 64'sd0 : a % b;
            default:  return 64'sd0;
        endcase
    endfunction

    function automatic int latency(input instruction_t ins);
        if ((ins.opcode == OP_DIV || ins.opcode == OP_MOD) && ins.operand_b != 0)
            return DIVC + 3;
        return 3;
    endfunction

    function automatic int rnd_operand();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 1;
            2: return -1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return int'($urandom_range(0, 40)) - 20;
            default: return int'($urandom);
        endcase
    endfunction

    // Launch a run and score every result_valid/done against the model, cycle by cycle.
    task automatic run(input int first, input int n, input bit pulse_mid);
        int     t_exp = 0;
        int     vi = 0;
        int     done_cnt = 0;
        int     done_at = -1;
        int     horizon;
        int     exp_at[$];
        int     exp_addr[$];
        longint exp_res[$];
        for (int i = 0; i < n; i++) begin
            int a = (first + i) % 32;
            t_exp += latency(mem[a]);
            exp_at.push_back(t_exp);
            exp_addr.push_back(a);
            exp_res.push_back(model(mem[a]));
        end
        horizon = t_exp + 4;
        @(negedge clk);
        first_addr = 5'(first);
        count      = 6'(n);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        first_addr = 5'($urandom);
        count      = 6'($urandom);
        for (int c = 1; c <= horizon; c++) begin
            if (result_valid) begin
                if (vi < n) begin
                    check("result", result, exp_res[vi]);
                    check("result_addr", 64'(result_addr), 64'(exp_addr[vi]));
                    check("valid_cycle", 64'(c), 64'(exp_at[vi]));
                end
                vi++;
            end
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            start = (pulse_mid && c == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("valid_count", 64'(vi), 64'(n));
        check("done_count", 64'(done_cnt), 64'd1);
        check("done_cycle", 64'(done_at), 64'(t_exp + 1));
        check("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = mk(OP_ZERO, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_read_pointer", 64'(read_pointer), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_result_addr", 64'(result_addr), 64'd0);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;

        mem[0] = mk(OP_ADD, 5, 3);
        run(0, 1, 1'b0);

        mem[30] = mk(OP_SUB, 3, 10);
        mem[31] = mk(OP_MULT, -7, 6);
        mem[0]  = mk(OP_PASSB, 1, -9);
        run(30, 3, 1'b1);

        mem[4] = mk(OP_DIV, -17, 5);
        mem[5] = mk(OP_MOD, -17, 5);
        run(4, 2, 1'b0);

        mem[10] = mk(OP_DIV, 9, 0);
        mem[11] = mk(OP_MOD, 9, 0);
        mem[12] = mk(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        mem[13] = mk(OP_DIV, 32'h8000_0000, -1);
        mem[14] = mk(opcode_t'(4'd11), 4, 4);
        run(10, 5, 1'b0);

        run(17, 0, 1'b0);

        mem[7] = mk(OP_DIV, 1000, -7);
        mem[8] = mk(OP_MOD, 1000, -7);
        @(negedge clk);
        first_addr = 5'd7;
        count      = 6'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_read_pointer", 64'(read_pointer), 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_result_addr", 64'(result_addr), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(result_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run(7, 2, 1'b0);

        for (int r = 0; r < 16; r++) begin
            int f = int'($urandom_range(0, 31));
            int n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++)
                mem[(f + i) % 32] = mk(opcode_t'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
            run(f, n, r[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
